calc_driver: RTL and testbench
==============================

CALC_DRIVER -- requirements
Module: calc_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports in_valid (input, 1) and in_ready (output, 1): host offers an operand triple; the triple is accepted when both are 1 in the same cycle.
REQ-004 SHALL have ports in_A, in_B, in_C, each input, 32 bits: host operand triple.
REQ-005 SHALL have ports A, B, C, each output, 32 bits: operands driven to the calc block.
REQ-006 SHALL have ports pushA, pushB, pushC, each output, 1 bit: operand valid, one per channel.
REQ-007 SHALL have ports stopA, stopB, stopC, each input, 1 bit: calc backpressure, one per channel.
REQ-008 SHALL have ports Z (input, 32) and pushZ (input, 1): result from calc; there is no stop, so each pulse is one result.
REQ-009 SHALL have ports res_data (output, 32), res_valid (output, 1) and res_pop (input, 1): host result read.
REQ-010 SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-011 SHALL hold operand triples in a 4-entry FIFO; in_ready=1 iff that FIFO is not full; an accepted triple is written the same cycle.
REQ-012 SHALL count a channel transfer in any cycle with pushX=1 and stopX=0.
REQ-013 SHALL use send FSM states IDLE and SEND.
REQ-014 SHALL move from IDLE to SEND on the next edge when the operand FIFO is non-empty and inflight<4; inflight SHALL increment on that edge.
REQ-015 SHALL, in SEND, drive A/B/C from the operand FIFO head and assert pushX for each channel whose done bit is clear.
REQ-016 SHALL set done[X] on the edge of channel X's transfer, after which pushX SHALL be 0 for the rest of that triple.
REQ-017 SHALL, when all three done bits would be set (prior done OR this cycle's transfers), pop the operand FIFO, clear done, and return to IDLE.
REQ-018 SHALL hold A/B/C stable while the corresponding pushX=1 and the transfer has not yet happened.
REQ-019 SHALL, if an operand FIFO write and pop coincide, perform both; occupancy is unchanged.
REQ-020 SHALL store Z into a 4-entry result FIFO on each pushZ=1 cycle.
REQ-021 SHALL drive res_valid=1 iff the result FIFO is non-empty, with res_data=head.
REQ-022 SHALL pop the result FIFO when res_pop=1 and res_valid=1; res_pop while empty SHALL be ignored.
REQ-023 SHALL decrement inflight (0..4) on each result-FIFO pop; a same-cycle increment and decrement leave it unchanged.
REQ-024 SHALL set err when pushZ arrives while result-FIFO occupancy equals inflight, i.e. an unexpected result; that Z SHALL be dropped. Because of REQ-014, the result FIFO cannot overflow otherwise.
REQ-025 SHALL keep err set until rst.
REQ-026 SHALL use 3-bit pointers with wrap-around modulo 4, with full/empty decided by pointer MSB comparison.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, empty both FIFOs, set inflight=0, set FSM=IDLE, clear done and clear err.
REQ-028 SHALL have outputs after reset: pushA/B/C=0, A/B/C=0, res_valid=0, res_data=0, err=0, in_ready=1.
REQ-029 SHALL let rst mid-SEND abandon the partial triple; pushes drop on the next cycle.
REQ-030 SHALL give rst priority over all simultaneous events.

Verification
REQ-031 SHALL cover: write (1,2,3), stop=0 -> pushA/B/C high one cycle with A=1,B=2,C=3, then low; inflight=1.
REQ-032 SHALL cover: stopB=1 for 3 cycles -> pushA and pushC drop after 1 cycle; pushB with B held holds 3 more cycles; next triple does not start until B transfers.
REQ-033 SHALL cover: write 6 triples with res_pop=0 and pushZ returned per triple -> exactly 4 sent, in_ready=0 after FIFO full; res_pop releases one more send each.
REQ-034 SHALL cover: pushZ with inflight=0 -> err=1 and stays 1, res_valid stays 0.
REQ-035 SHALL cover: Z values 10,20,30 -> res_data 10,20,30 in order under res_pop; res_pop on empty -> no change.
REQ-036 SHALL cover: rst after pushA transfers but before B/C -> all pushes 0, in_ready=1, inflight=0 next cycle.

Source files
------------

// File: rtl/calc_driver.sv
// ----------------------------------------------------------------------------
// calc_driver
// Bridges a host operand/result interface to a three-channel calc block.
// Host operand triples are queued in a 4-entry FIFO. A send FSM presents the
// head triple on A/B/C. Each channel completes independently under its own
// stop backpressure. Results returned on Z/pushZ are queued in a 4-entry
// result FIFO for the host to pop. At most four triples may be outstanding
// (sent but not yet popped by the host), so every expected result has room.
// A result arriving with nothing outstanding is dropped and raises a sticky
// err flag.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     host operand handshake
//   in_A/in_B/in_C        host operand triple
//   A/B/C                 operands to calc
//   pushA/pushB/pushC     per-channel operand valid
//   stopA/stopB/stopC     per-channel calc backpressure
//   Z, pushZ              result from calc, one result per pulse
//   res_data/res_valid    host result head
//   res_pop               host result pop
//   err                   sticky unexpected-result flag
// ----------------------------------------------------------------------------
module calc_driver (
    input  logic        clk,
    input  logic        rst,
    // host operand side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_A,
    input  logic [31:0] in_B,
    input  logic [31:0] in_C,
    // calc operand side
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] C,
    output logic        pushA,
    output logic        pushB,
    output logic        pushC,
    input  logic        stopA,
    input  logic        stopB,
    input  logic        stopC,
    // calc result side
    input  logic [31:0] Z,
    input  logic        pushZ,
    // host result side
    output logic [31:0] res_data,
    output logic        res_valid,
    input  logic        res_pop,
    // status
    output logic        err
);

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned PW    = AW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DW-1:0] r_opa_mem [DEPTH];
    logic [DW-1:0] r_opb_mem [DEPTH];
    logic [DW-1:0] r_opc_mem [DEPTH];
    logic [PW-1:0] r_op_wr;
    logic [PW-1:0] r_op_rd;

    logic [DW-1:0] r_res_mem [DEPTH];
    logic [PW-1:0] r_res_wr;
    logic [PW-1:0] r_res_rd;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_done;
    logic [2:0]    w_done_nxt;
    logic [PW-1:0] r_inflight;
    logic          r_err;

    logic          w_op_empty;
    logic          w_op_full;
    logic          w_op_push;
    logic          w_op_pop;
    logic          w_launch;
    logic [2:0]    w_stop;
    logic [2:0]    w_push;
    logic [2:0]    w_xfer;

    logic          w_res_empty;
    logic [PW-1:0] w_res_cnt;
    logic          w_res_unexp;
    logic          w_res_push;
    logic          w_res_pop;

    // ------------------------------------------------------------------
    // Operand FIFO: pointers carry one extra wrap bit for full/empty
    // ------------------------------------------------------------------
    assign w_op_empty = (r_op_wr == r_op_rd);
    assign w_op_full  = (r_op_wr[PW-1] != r_op_rd[PW-1]) &&
                        (r_op_wr[AW-1:0] == r_op_rd[AW-1:0]);
    assign w_op_push  = in_valid && !w_op_full;
    assign in_ready   = !w_op_full;

    // Operand pointer update; write and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_wr <= '0;
            r_op_rd <= '0;
        end else begin
            if (w_op_push) begin
                r_op_wr <= r_op_wr + PW'(1);
            end
            if (w_op_pop) begin
                r_op_rd <= r_op_rd + PW'(1);
            end
        end
    end

    // Operand storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_op_push) begin
            r_opa_mem[r_op_wr[AW-1:0]] <= in_A;
            r_opb_mem[r_op_wr[AW-1:0]] <= in_B;
            r_opc_mem[r_op_wr[AW-1:0]] <= in_C;
        end
    end

    // ------------------------------------------------------------------
    // Send FSM
    // ------------------------------------------------------------------
    assign w_stop = {stopC, stopB, stopA};

    // State and per-channel done register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state, channel pushes and FIFO pop
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = r_done;
        w_push      = '0;
        w_xfer      = '0;
        w_op_pop    = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            IDLE: begin
                // Launch only while an outstanding slot remains for its result
                if (!w_op_empty && (r_inflight < PW'(DEPTH))) begin
                    w_state_nxt = SEND;
                    w_launch    = 1'b1;
                end
            end
            SEND: begin
                w_push = ~r_done;
                w_xfer = w_push & ~w_stop;
                // Finish the triple once every channel has transferred
                if ((r_done | w_xfer) == 3'b111) begin
                    w_op_pop    = 1'b1;
                    w_done_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_done_nxt  = r_done | w_xfer;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_done_nxt  = '0;
            end
        endcase
    end

    assign pushA = w_push[0];
    assign pushB = w_push[1];
    assign pushC = w_push[2];

    // Head operands are only meaningful in SEND; zero otherwise
    assign A = (r_state == SEND) ? r_opa_mem[r_op_rd[AW-1:0]] : '0;
    assign B = (r_state == SEND) ? r_opb_mem[r_op_rd[AW-1:0]] : '0;
    assign C = (r_state == SEND) ? r_opc_mem[r_op_rd[AW-1:0]] : '0;

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    assign w_res_empty = (r_res_wr == r_res_rd);
    assign w_res_cnt   = r_res_wr - r_res_rd;
    // Outstanding results = inflight - occupancy; none outstanding means stray
    assign w_res_unexp = pushZ && (w_res_cnt == r_inflight);
    assign w_res_push  = pushZ && !w_res_unexp;
    assign w_res_pop   = res_pop && !w_res_empty;

    assign res_valid = !w_res_empty;
    assign res_data  = w_res_empty ? '0 : r_res_mem[r_res_rd[AW-1:0]];

    // Result pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_wr <= '0;
            r_res_rd <= '0;
        end else begin
            if (w_res_push) begin
                r_res_wr <= r_res_wr + PW'(1);
            end
            if (w_res_pop) begin
                r_res_rd <= r_res_rd + PW'(1);
            end
        end
    end

    // Result storage
    always_ff @(posedge clk) begin
        if (w_res_push) begin
            r_res_mem[r_res_wr[AW-1:0]] <= Z;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-triple counter: launch increments, host pop decrements
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_launch, w_res_pop})
                2'b10:   r_inflight <= r_inflight + PW'(1);
                2'b01:   r_inflight <= r_inflight - PW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sticky error on a result nobody is waiting for
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_res_unexp) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_calc_driver.sv
// ----------------------------------------------------------------------------
// tb_calc_driver
// Scoreboard bench for calc_driver. Stimulus pushes expected operands per
// channel and expected results into queues; a negedge monitor pops and
// compares on each channel transfer and each host result pop. A responder
// process plays the calc result path from a queue of Z values.
// ----------------------------------------------------------------------------
module tb_calc_driver;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [31:0] in_C;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic        pushA;
    logic        pushB;
    logic        pushC;
    logic        stopA;
    logic        stopB;
    logic        stopC;
    logic [31:0] Z;
    logic        pushZ;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_pop;
    logic        err;

    int          n_checks;
    int          n_errors;
    int          n_c_xfer;
    int          z_seq;
    bit          auto_z;

    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] qc [$];
    logic [31:0] qz [$];
    logic [31:0] zq_val [$];
    bit          zq_exp [$];

    calc_driver dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_C      (in_C),
        .A         (A),
        .B         (B),
        .C         (C),
        .pushA     (pushA),
        .pushB     (pushB),
        .pushC     (pushC),
        .stopA     (stopA),
        .stopB     (stopB),
        .stopC     (stopC),
        .Z         (Z),
        .pushZ     (pushZ),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_pop   (res_pop),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one triple and wait (bounded) until it is accepted
    task automatic write_triple(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int n;
        n = 0;
        in_A = a;
        in_B = b;
        in_C = c;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL write_timeout: in_ready stayed 0 for %0d cycles, expected acceptance", n);
        end
        tick();
        in_valid = 1'b0;
        qa.push_back(a);
        qb.push_back(b);
        qc.push_back(c);
    endtask

    // Pop exactly n results from the host side, bounded
    task automatic drain(input int n);
        int got;
        int k;
        got = 0;
        k = 0;
        while (got < n && k < 100) begin
            res_pop = res_valid;
            if (res_valid) got++;
            tick();
            k++;
        end
        res_pop = 1'b0;
        check("drain_count", 32'(got), 32'(n));
    endtask

    // Calc result path: one queued Z per cycle
    initial begin
        pushZ = 1'b0;
        Z     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (zq_val.size() > 0) begin
                pushZ = 1'b1;
                Z     = zq_val.pop_front();
                if (zq_exp.pop_front()) qz.push_back(Z);
            end else begin
                pushZ = 1'b0;
                Z     = '0;
            end
        end
    end

    // Monitor: compare every channel transfer and host pop against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pushA && !stopA) begin
                    if (qa.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL chanA: got transfer 0x%0h, expected none", A);
                    end else check("chanA", A, qa.pop_front());
                end
                if (pushB && !stopB) begin
                    if (qb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL chanB: got transfer 0x%0h, expected none", B);
                    end else check("chanB", B, qb.pop_front());
                end
                if (pushC && !stopC) begin
                    n_c_xfer++;
                    if (qc.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL chanC: got transfer 0x%0h, expected none", C);
                    end else check("chanC", C, qc.pop_front());
                    if (auto_z) begin
                        zq_val.push_back(32'h500 + 32'(z_seq));
                        zq_exp.push_back(1'b1);
                        z_seq++;
                    end
                end
                if (res_valid && res_pop) begin
                    if (qz.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL result: got pop 0x%0h, expected none", res_data);
                    end else check("result", res_data, qz.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        n_checks = 0;
        n_errors = 0;
        n_c_xfer = 0;
        z_seq    = 0;
        auto_z   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_A     = '0;
        in_B     = '0;
        in_C     = '0;
        stopA    = 1'b0;
        stopB    = 1'b0;
        stopC    = 1'b0;
        res_pop  = 1'b0;

        // Reset state
        tick_n(2);
        check("rst_pushA", 32'(pushA), 32'd0);
        check("rst_pushB", 32'(pushB), 32'd0);
        check("rst_pushC", 32'(pushC), 32'd0);
        check("rst_A", A, 32'd0);
        check("rst_B", B, 32'd0);
        check("rst_C", C, 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Single triple, no backpressure
        write_triple(32'd1, 32'd2, 32'd3);
        tick();
        check("t1_pushA", 32'(pushA), 32'd1);
        check("t1_pushB", 32'(pushB), 32'd1);
        check("t1_pushC", 32'(pushC), 32'd1);
        check("t1_A", A, 32'd1);
        check("t1_B", B, 32'd2);
        check("t1_C", C, 32'd3);
        check("t1_inflight", 32'(dut.r_inflight), 32'd1);
        tick();
        check("t1_pushA_low", 32'(pushA), 32'd0);
        check("t1_pushB_low", 32'(pushB), 32'd0);
        check("t1_pushC_low", 32'(pushC), 32'd0);
        check("t1_inflight_hold", 32'(dut.r_inflight), 32'd1);
        zq_val.push_back(32'd100);
        zq_exp.push_back(1'b1);
        drain(1);
        tick();
        check("t1_inflight_zero", 32'(dut.r_inflight), 32'd0);
        check("t1_res_valid", 32'(res_valid), 32'd0);

        // stopB held three cycles; second triple must wait for B
        stopB    = 1'b1;
        in_A     = 32'd4;
        in_B     = 32'd5;
        in_C     = 32'd6;
        in_valid = 1'b1;
        qa.push_back(32'd4);
        qb.push_back(32'd5);
        qc.push_back(32'd6);
        tick();
        in_A = 32'd7;
        in_B = 32'd8;
        in_C = 32'd9;
        qa.push_back(32'd7);
        qb.push_back(32'd8);
        qc.push_back(32'd9);
        tick();
        in_valid = 1'b0;
        check("t2_s1_pushA", 32'(pushA), 32'd1);
        check("t2_s1_pushB", 32'(pushB), 32'd1);
        check("t2_s1_pushC", 32'(pushC), 32'd1);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t2_hold_pushA", 32'(pushA), 32'd0);
            check("t2_hold_pushC", 32'(pushC), 32'd0);
            check("t2_hold_pushB", 32'(pushB), 32'd1);
            check("t2_hold_B", B, 32'd5);
        end
        stopB = 1'b0;
        tick();
        check("t2_done_pushA", 32'(pushA), 32'd0);
        check("t2_done_pushB", 32'(pushB), 32'd0);
        tick();
        check("t3_pushA", 32'(pushA), 32'd1);
        check("t3_A", A, 32'd7);
        tick();
        check("t3_inflight", 32'(dut.r_inflight), 32'd2);
        zq_val.push_back(32'd200);
        zq_exp.push_back(1'b1);
        zq_val.push_back(32'd300);
        zq_exp.push_back(1'b1);
        drain(2);
        check("t3_inflight_zero", 32'(dut.r_inflight), 32'd0);

        // Results 10,20,30 in order; pop on empty ignored
        write_triple(32'h21, 32'h22, 32'h23);
        write_triple(32'h31, 32'h32, 32'h33);
        write_triple(32'h41, 32'h42, 32'h43);
        tick_n(10);
        check("r_inflight3", 32'(dut.r_inflight), 32'd3);
        zq_val.push_back(32'd10);
        zq_exp.push_back(1'b1);
        zq_val.push_back(32'd20);
        zq_exp.push_back(1'b1);
        zq_val.push_back(32'd30);
        zq_exp.push_back(1'b1);
        tick_n(5);
        check("r_head", res_data, 32'd10);
        drain(3);
        res_pop = 1'b1;
        tick_n(2);
        res_pop = 1'b0;
        check("r_empty_valid", 32'(res_valid), 32'd0);
        check("r_empty_data", res_data, 32'd0);
        check("r_empty_inflight", 32'(dut.r_inflight), 32'd0);
        check("r_empty_err", 32'(err), 32'd0);

        // Six triples, no host pops: only four go out
        auto_z = 1'b1;
        stopA  = 1'b1;
        c0     = n_c_xfer;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                check("f_in_ready_full", 32'(in_ready), 32'd0);
                stopA = 1'b0;
            end
            write_triple(32'h100 + 32'(k), 32'h200 + 32'(k), 32'h300 + 32'(k));
        end
        tick_n(40);
        check("f_sent4", 32'(n_c_xfer - c0), 32'd4);
        check("f_inflight4", 32'(dut.r_inflight), 32'd4);
        check("f_pushA_stall", 32'(pushA), 32'd0);
        check("f_in_ready", 32'(in_ready), 32'd1);
        drain(1);
        tick_n(10);
        check("f_sent5", 32'(n_c_xfer - c0), 32'd5);
        drain(1);
        tick_n(10);
        check("f_sent6", 32'(n_c_xfer - c0), 32'd6);
        drain(4);
        tick_n(5);
        check("f_inflight0", 32'(dut.r_inflight), 32'd0);
        check("f_res_valid0", 32'(res_valid), 32'd0);
        auto_z = 1'b0;

        // Stray result with nothing outstanding
        zq_val.push_back(32'd77);
        zq_exp.push_back(1'b0);
        tick_n(4);
        check("e_err_set", 32'(err), 32'd1);
        check("e_res_valid", 32'(res_valid), 32'd0);
        tick_n(4);
        check("e_err_sticky", 32'(err), 32'd1);
        check("e_res_valid_hold", 32'(res_valid), 32'd0);

        // Reset mid-triple after A transferred
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("m_err_clear", 32'(err), 32'd0);
        stopB = 1'b1;
        stopC = 1'b1;
        write_triple(32'hA, 32'hB, 32'hC);
        tick();
        check("m_pushA", 32'(pushA), 32'd1);
        tick();
        check("m_pushA_done", 32'(pushA), 32'd0);
        check("m_pushB_wait", 32'(pushB), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qb.delete();
        qc.delete();
        check("m_pushA_rst", 32'(pushA), 32'd0);
        check("m_pushB_rst", 32'(pushB), 32'd0);
        check("m_pushC_rst", 32'(pushC), 32'd0);
        check("m_in_ready_rst", 32'(in_ready), 32'd1);
        check("m_inflight_rst", 32'(dut.r_inflight), 32'd0);
        stopB = 1'b0;
        stopC = 1'b0;
        tick_n(3);
        check("m_no_resume_A", 32'(pushA), 32'd0);
        check("m_no_resume_B", 32'(pushB), 32'd0);
        auto_z = 1'b1;
        write_triple(32'd1, 32'd2, 32'd3);
        tick_n(6);
        drain(1);
        auto_z = 1'b0;
        tick();
        check("m_inflight_end", 32'(dut.r_inflight), 32'd0);

        // Nothing left unmatched
        check("end_qa", 32'(qa.size()), 32'd0);
        check("end_qb", 32'(qb.size()), 32'd0);
        check("end_qc", 32'(qc.size()), 32'd0);
        check("end_qz", 32'(qz.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
